// File: rtl/cla_multiword_add_seq.sv
// Multi-precision add/subtract sequencer: streams two W-bit operands LSB byte
// first through one shared 8-bit carry-lookahead adder, chaining the carry
// through a register, then reports result, carry-out and signed overflow.

// 8-bit carry-lookahead adder: every carry is a flat sum of generate terms
// gated by the propagate run above them.
module carry_lookahead_adder_8b (
    input  logic [7:0] iA,
    input  logic [7:0] iB,
    input  logic       iCarryIn,
    output logic [7:0] oSum,
    output logic       oCarry
);
    logic [7:0] gen;
    logic [7:0] prop;
    logic [8:0] carry;
    logic       propRun;

    assign gen  = iA & iB;
    assign prop = iA ^ iB;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        carry    = '0;
        propRun  = 1'b0;
        carry[0] = iCarryIn;
        for (int i = 0; i < 8; i++) begin
            carry[i+1] = gen[i];
            propRun    = prop[i];
            for (int j = 7; j >= 0; j--) begin
                if (j < i) begin
                    carry[i+1] = carry[i+1] | (propRun & gen[j]);
                    propRun    = propRun & prop[j];
                end
            end
            carry[i+1] = carry[i+1] | (propRun & iCarryIn);
        end
    end

    assign oSum   = prop ^ carry[7:0];
    assign oCarry = carry[8];
endmodule

module cla_multiword_add_seq #(
    parameter int unsigned NUM_BYTES = 4
) (
    input  logic                   iClk,
    input  logic                   iRstn,
    input  logic                   iStart,
    input  logic                   iSub,
    input  logic                   iCarryIn,
    input  logic [8*NUM_BYTES-1:0] iA,
    input  logic [8*NUM_BYTES-1:0] iB,
    output logic                   oBusy,
    output logic                   oDone,
    output logic [8*NUM_BYTES-1:0] oResult,
    output logic                   oCarry,
    output logic                   oOverflow
);
    localparam int unsigned W     = 8 * NUM_BYTES;
    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [IDX_W-1:0] byteIdx;
    logic [IDX_W+2:0] byteOff;
    logic             carryReg;
    logic [W-1:0]     aReg;
    logic [W-1:0]     bReg;
    logic [7:0]       claA;
    logic [7:0]       claB;
    logic [7:0]       claSum;
    logic             claCarry;
    logic             isLast;

    assign byteOff = {byteIdx, 3'b000};
    assign claA    = aReg[byteOff +: 8];
    assign claB    = bReg[byteOff +: 8];
    assign isLast  = (byteIdx == LAST_IDX);

    carry_lookahead_adder_8b uCla (
        .iA       (claA),
        .iB       (claB),
        .iCarryIn (carryReg),
        .oSum     (claSum),
        .oCarry   (claCarry)
    );

    // State register
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: one RUN cycle per byte, one DONE cycle, back to IDLE
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iStart) stateNext = RUN;
            RUN:     if (isLast) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Status flags registered from the upcoming state so they align with it
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            oBusy <= 1'b0;
            oDone <= 1'b0;
        end else begin
            oBusy <= (stateNext != IDLE);
            oDone <= (stateNext == DONE);
        end
    end

    // Operand latch, byte-serial datapath and result/flag registers
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            aReg      <= '0;
            bReg      <= '0;
            carryReg  <= 1'b0;
            byteIdx   <= '0;
            oResult   <= '0;
            oCarry    <= 1'b0;
            oOverflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        aReg      <= iA;
                        bReg      <= iSub ? ~iB : iB;
                        carryReg  <= iSub ? 1'b1 : iCarryIn;
                        byteIdx   <= '0;
                        oResult   <= '0;
                        oCarry    <= 1'b0;
                        oOverflow <= 1'b0;
                    end
                end
                RUN: begin
                    oResult[byteOff +: 8] <= claSum;
                    carryReg              <= claCarry;
                    if (isLast) begin
                        byteIdx   <= '0;
                        oCarry    <= claCarry;
                        oOverflow <= (aReg[W-1] == bReg[W-1]) && (claSum[7] != aReg[W-1]);
                    end else begin
                        byteIdx <= byteIdx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// Bench for cla_multiword_add_seq: directed corner cases plus random operands,
// expected responses queued at issue and popped by an oDone monitor.
module tb_cla_multiword_add_seq;
    localparam int unsigned NUM_BYTES = 4;
    localparam int unsigned W         = 8 * NUM_BYTES;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;

    exp_t expQ[$];
    int   checks    = 0;
    int   failures  = 0;
    int   doneSeen  = 0;
    int   issued    = 0;

    cla_multiword_add_seq #(.NUM_BYTES(NUM_BYTES)) dut (
        .iClk      (clk),
        .iRstn     (rstn),
        .iStart    (start),
        .iSub      (sub),
        .iCarryIn  (cin),
        .iA        (a),
        .iB        (b),
        .oBusy     (busy),
        .oDone     (done),
        .oResult   (result),
        .oCarry    (carry),
        .oOverflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the whole words
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic ci);
        exp_t          e;
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        longint unsigned full;
        longint        sx = longint'($signed(x));
        longint        sy = longint'($signed(y));
        longint        sr;
        longint        maxS = (longint'(1) << (W - 1)) - 1;
        longint        minS = -(longint'(1) << (W - 1));
        if (s) begin
            full    = ux - uy;
            e.carry = (ux >= uy);
            sr      = sx - sy;
        end else begin
            full    = ux + uy + 64'(ci);
            e.carry = full[W];
            sr      = sx + sy + longint'(ci);
        end
        e.res = full[W-1:0];
        e.ovf = (sr > maxS) || (sr < minS);
        return e;
    endfunction

    // Monitor: every oDone must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            doneSeen++;
            chk("done_has_expectation", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("carry", 64'(carry), 64'(e.carry));
                chk("overflow", 64'(overflow), 64'(e.ovf));
                chk("busy_in_done", 64'(busy), 64'd1);
            end
        end
    end

    task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input logic ci, input bit extraPulses);
        exp_t e;
        int   edges;
        bit   got;
        @(negedge clk);
        a = x; b = y; sub = s; cin = ci; start = 1'b1;
        @(posedge clk);
        e = model(x, y, s, ci);
        expQ.push_back(e);
        issued++;
        #1;
        chk("clear_on_start", 64'(result), 64'd0);
        chk("busy_after_start", 64'(busy), 64'd1);
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        start = extraPulses;
        edges = 1;
        got   = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
            start = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("latency_edges", 64'(edges), 64'(NUM_BYTES + 1));
        if (extraPulses) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_single_cycle", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("no_queued_start", 64'(busy), 64'd0);
        chk("hold_result", 64'(result), 64'(e.res));
        chk("hold_carry", 64'(carry), 64'(e.carry));
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_carry"}, 64'(carry), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t pe;
        int   doneBefore;
        rstn = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        runOp(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        runOp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        runOp(32'd5,         32'd7,         1'b1, 1'b0, 1'b0);
        runOp(32'd7,         32'd5,         1'b1, 1'b1, 1'b0);
        runOp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        runOp(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        runOp(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 1'b1);

        // Abort mid-operation after two bytes have been produced
        @(negedge clk);
        a = 32'h89AB_CDEF; b = 32'h1111_2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pe = model(32'h89AB_CDEF, 32'h1111_2222, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("partial_result", 64'(result), 64'(pe.res & 32'h0000_FFFF));
        doneBefore = doneSeen;
        rstn = 1'b0;
        #1;
        checkResetOutputs("abort");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (NUM_BYTES + 3) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(doneSeen), 64'(doneBefore));
        checkResetOutputs("after_abort");

        runOp(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            runOp(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 64'(expQ.size()), 64'd0);
        chk("done_count", 64'(doneSeen), 64'(issued));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
